instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 23 ++
 rtl/instr_fetch_unit_fifo.sv | 68 ++++++
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package instr_fetch_unit_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam int unsigned FETCH_BYTES      = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DROP
    } fetch_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [63:0] line_base(input logic [63:0] addr);
        return {addr[63:3], 3'b000};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Instruction queue: synchronous FIFO with two ordered write ports (a before b),
// one read port, flush, and a combinational head entry.
module inst_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         flush_i,
    input  logic         wr_en_a_i,
    input  fetch_entry_t wr_data_a_i,
    input  logic         wr_en_b_i,
    input  fetch_entry_t wr_data_b_i,
    input  logic         rd_en_i,
    output logic         empty_o,
    output logic [AW:0]  count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] slot_b;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = rd_en_i && !empty_o;
    // Port b lands directly behind port a when both write in the same cycle.
    assign slot_b  = wr_ptr_q + AW'(wr_en_a_i);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_en_a_i) + AW'(wr_en_b_i);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(wr_en_a_i) + (AW+1)'(wr_en_b_i) - (AW+1)'(do_pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; entries are only observed through count_q,
    // which is reset, so clearing the array would only cost flops.
    always_ff @(posedge clock) begin
        if (!flush_i) begin
            if (wr_en_a_i) mem_q[wr_ptr_q] <= wr_data_a_i;
            if (wr_en_b_i) mem_q[slot_b]   <= wr_data_b_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one-outstanding 8-byte line fetch feeding an instruction queue.
// Optional macro FETCH_PERF_EN adds the perf_empty_cycles counter output.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [63:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    input  logic        fifo_read_en,
    output logic        fifo_empty,
    output logic [31:0] fifo_data_out,
    output logic [63:0] fifo_pc_out
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_empty_cycles
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    fetch_state_e state_q, state_d;
    logic [63:0]  fetch_pc_q, fetch_pc_d;
    logic [AW:0]  count;
    logic         has_room;
    logic         push_lo, push_hi, flush, pop;
    fetch_entry_t entry_lo, entry_hi, head;
    logic         unused_target_bits;

    assign unused_target_bits = ^redirect_target[1:0];

    assign has_room      = (count <= (AW+1)'(FIFO_DEPTH - 2));
    assign imem_req_addr = line_base(fetch_pc_q);
    assign pop           = fifo_read_en && !redirect_valid;

    assign entry_lo = '{pc: line_base(fetch_pc_q),          instr: imem_resp_data[31:0]};
    assign entry_hi = '{pc: line_base(fetch_pc_q) | 64'h4, instr: imem_resp_data[63:32]};

    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        imem_req_valid = 1'b0;
        push_lo        = 1'b0;
        push_hi        = 1'b0;
        flush          = 1'b0;

        unique case (state_q)
            ST_IDLE: if (has_room) state_d = ST_REQ;
            ST_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    push_lo    = !fetch_pc_q[2];
                    push_hi    = 1'b1;
                    fetch_pc_d = line_base(fetch_pc_q) + 64'(FETCH_BYTES);
                    state_d    = ST_IDLE;
                end
            end
            ST_DROP: if (imem_resp_valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A redirect overrides everything; if a response is still owed the
        // FSM parks in DROP so that stale line never reaches the queue.
        if (redirect_valid) begin
            flush      = 1'b1;
            push_lo    = 1'b0;
            push_hi    = 1'b0;
            fetch_pc_d = {redirect_target[63:2], 2'b00};
            unique case (state_q)
                ST_REQ:  state_d = imem_req_ready  ? ST_DROP : ST_IDLE;
                ST_WAIT: state_d = imem_resp_valid ? ST_IDLE : ST_DROP;
                ST_DROP: state_d = imem_resp_valid ? ST_IDLE : ST_DROP;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the comb block
    // above uses blocking ones and gives every output a default to avoid latches.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    inst_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush_i     (flush),
        .wr_en_a_i   (push_lo),
        .wr_data_a_i (entry_lo),
        .wr_en_b_i   (push_hi),
        .wr_data_b_i (entry_hi),
        .rd_en_i     (pop),
        .empty_o     (fifo_empty),
        .count_o     (count),
        .head_o      (head)
    );

    assign fifo_data_out = head.instr;
    assign fifo_pc_out   = head.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_q <= '0;
        end else if (fifo_empty && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_empty_cycles = perf_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (FIFO_DEPTH=8).
module tb_instr_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [63:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        fifo_read_en;
    logic        fifo_empty;
    logic [31:0] fifo_data_out;
    logic [63:0] fifo_pc_out;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_empty_cycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    instr_fetch_unit #(
        .FIFO_DEPTH (8),
        .RESET_PC   (64'h0000_0000_8000_0000)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fifo_read_en    (fifo_read_en),
        .fifo_empty      (fifo_empty),
        .fifo_data_out   (fifo_data_out),
        .fifo_pc_out     (fifo_pc_out)
`ifdef FETCH_PERF_EN
        ,
        .perf_empty_cycles (perf_empty_cycles)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req_valid && n < 20) begin
            step();
            n++;
        end
        check(tag, imem_req_valid, 1);
    endtask

    task automatic handshake();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [63:0] data);
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        step();
        imem_resp_valid = 1'b0;
    endtask

    task automatic pop();
        fifo_read_en = 1'b1;
        step();
        fifo_read_en = 1'b0;
    endtask

    initial begin
        reset_n         = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        fifo_read_en    = 1'b0;
        step();
        step();
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_empty",     fifo_empty,     1);
        check("rst_addr",      imem_req_addr,  64'h8000_0000);

        // First request appears right after the first edge past reset release.
        reset_n = 1'b1;
        step();
        check("first_req_valid", imem_req_valid, 1);
        check("first_req_addr",  imem_req_addr,  64'h8000_0000);

`ifdef FETCH_PERF_EN
        for (int i = 0; i < 10; i++) step();
        check("perf_ge_10", (perf_empty_cycles >= 32'd10), 1);
        check("addr_stable", imem_req_addr, 64'h8000_0000);
`endif

        handshake();
        check("wait_no_valid", imem_req_valid, 0);
        respond(64'h00000013_00100093);
        check("line0_empty", fifo_empty,    0);
        check("line0_pc0",   fifo_pc_out,   64'h8000_0000);
        check("line0_d0",    fifo_data_out, 64'h0010_0093);
        wait_req("req_line1");
        check("line1_addr", imem_req_addr, 64'h8000_0008);
        pop();
        check("line0_pc1", fifo_pc_out,   64'h8000_0004);
        check("line0_d1",  fifo_data_out, 64'h0000_0013);
        pop();
        check("drained", fifo_empty, 1);
        pop();
        check("pop_empty_ignored", fifo_empty, 1);

        // Redirect mid-line: only the high word is queued.
        redirect_valid  = 1'b1;
        redirect_target = 64'h8000_0016;
        step();
        redirect_valid = 1'b0;
        check("redir_idle", imem_req_valid, 0);
        wait_req("req_redir");
        check("redir_addr", imem_req_addr, 64'h8000_0010);
        handshake();
        respond(64'hAAAA_BBBB_CCCC_DDDD);
        check("redir_pc",   fifo_pc_out,   64'h8000_0014);
        check("redir_data", fifo_data_out, 64'hAAAA_BBBB);
        pop();
        check("redir_one_entry", fifo_empty, 1);
        wait_req("req_after_redir");
        check("after_redir_addr", imem_req_addr, 64'h8000_0018);

        // Redirect while waiting: the late response is discarded.
        handshake();
        redirect_valid  = 1'b1;
        redirect_target = 64'h8000_0100;
        step();
        redirect_valid = 1'b0;
        check("drop_no_req", imem_req_valid, 0);
        step();
        step();
        check("drop_still_no_req", imem_req_valid, 0);
        respond(64'hDEAD_BEEF_DEAD_BEEF);
        check("drop_discarded", fifo_empty, 1);
        wait_req("req_after_drop");
        check("after_drop_addr", imem_req_addr, 64'h8000_0100);

        // Fill the queue with no consumer: exactly four lines fit.
        for (int i = 0; i < 4; i++) begin
            wait_req("fill_req");
            handshake();
            respond({32'h2000_0001 + 32'(2*i), 32'h2000_0000 + 32'(2*i)});
        end
        step();
        step();
        step();
        check("full_no_req",  imem_req_valid, 0);
        check("full_head_pc", fifo_pc_out,    64'h8000_0100);
        check("full_head_d",  fifo_data_out,  64'h2000_0000);
        pop();
        step();
        step();
        check("seven_no_req", imem_req_valid, 0);
        pop();
        wait_req("six_req");
        check("six_addr",    imem_req_addr, 64'h8000_0120);
        check("six_head_pc", fifo_pc_out,   64'h8000_0108);

        // Pop and push together at six entries leaves seven.
        handshake();
        fifo_read_en = 1'b1;
        respond(64'h3000_0001_3000_0000);
        fifo_read_en = 1'b0;
        check("popush_head", fifo_pc_out, 64'h8000_010C);
        step();
        step();
        step();
        check("popush_seven_no_req", imem_req_valid, 0);
        pop();
        check("back_to_six_head", fifo_pc_out, 64'h8000_0110);
        wait_req("six_again_req");
        check("six_again_addr", imem_req_addr, 64'h8000_0128);

        // Redirect alongside pop and response clears everything.
        handshake();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 64'h4000_0001_4000_0000;
        fifo_read_en    = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 64'h8000_0200;
        step();
        imem_resp_valid = 1'b0;
        fifo_read_en    = 1'b0;
        redirect_valid  = 1'b0;
        check("redir_clear_empty", fifo_empty, 1);
        wait_req("req_after_clear");
        check("after_clear_addr", imem_req_addr, 64'h8000_0200);

        // Fetch PC wraps modulo 2^64.
        redirect_valid  = 1'b1;
        redirect_target = 64'hFFFF_FFFF_FFFF_FFFD;
        step();
        redirect_valid = 1'b0;
        wait_req("req_top");
        check("top_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        handshake();
        respond(64'h1234_5678_9ABC_DEF0);
        check("top_pc",   fifo_pc_out,   64'hFFFF_FFFF_FFFF_FFFC);
        check("top_data", fifo_data_out, 64'h1234_5678);
        wait_req("req_wrap");
        check("wrap_addr", imem_req_addr, 64'h0);

        // Reset in the middle of a transaction abandons it.
        handshake();
        reset_n = 1'b0;
        #1;
        check("midrst_req_valid", imem_req_valid, 0);
        check("midrst_empty",     fifo_empty,     1);
        check("midrst_addr",      imem_req_addr,  64'h8000_0000);
        step();
        reset_n = 1'b1;
        step();
        check("post_rst_req", imem_req_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
